// File: rtl/sa_pkg.sv
// sa_pkg: shared constants and types for the systolic array front end.
package sa_pkg;
    localparam int ELEM_W = 8;
    localparam int ACC_W = 16;

    typedef enum logic [1:0] {IDLE, FEED, DONE} feed_state_t;

    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction
endpackage

// File: rtl/sa_skew_feeder_lane.sv
// sa_skew_feeder_lane: one edge lane, loaded with N elements preceded by D zero slots, shifted out one per cycle.
module sa_skew_feeder_lane #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int D = 0
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    input  logic           i_load,
    input  logic [N*W-1:0] i_vec,
    output logic [W-1:0]   o_lane
);
    localparam int L = N + D;

    // Slot j is what the lane shows j cycles after the load; zeros refill the tail.
    logic [W-1:0] sr [L];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int j = 0; j < L; j++) sr[j] <= '0;
        end else if (i_load) begin
            for (int j = 0; j < D; j++) sr[j] <= '0;
            for (int j = 0; j < N; j++) sr[D+j] <= i_vec[j*W +: W];
        end else begin
            for (int j = 0; j < L - 1; j++) sr[j] <= sr[j+1];
            sr[L-1] <= '0;
        end
    end

    assign o_lane = sr[0];
endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: captures A/B in one handshake and feeds them diagonally skewed
// onto the west/north edges of the NxN systolic array, pulsing done when results are final.
module sa_skew_feeder #(
    parameter int N = 4,
    parameter int ELEM_W = sa_pkg::ELEM_W
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_start_valid,
    output logic                  o_start_ready,
    input  logic [N*N*ELEM_W-1:0] i_a,
    input  logic [N*N*ELEM_W-1:0] i_b,
    output logic [N*ELEM_W-1:0]   o_a,
    output logic [N*ELEM_W-1:0]   o_b,
    output logic                  o_busy,
    output logic                  o_done
);
    import sa_pkg::*;

    localparam int FL = feed_len(N);
    localparam int CW = $clog2(FL);
    localparam logic [CW-1:0] T_LAST = CW'(FL - 1);

    feed_state_t   state;
    logic [CW-1:0] t;
    logic          accept;

    assign accept = state == IDLE && i_start_valid;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= IDLE;
            t <= '0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
            o_start_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (i_start_valid) begin
                    state <= FEED;
                    t <= '0;
                    o_busy <= 1'b1;
                    o_start_ready <= 1'b0;
                end
                FEED: if (t == T_LAST) begin
                    state <= DONE;
                    o_done <= 1'b1;
                end else begin
                    t <= t + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    o_start_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row r of A is contiguous in i_a; delaying it by r cycles gives A[r][t-r].
    for (genvar r = 0; r < N; r++) begin : g_row
        sa_skew_feeder_lane #(.N(N), .W(ELEM_W), .D(r)) u_lane (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .i_load   (accept),
            .i_vec    (i_a[r*N*ELEM_W +: N*ELEM_W]),
            .o_lane   (o_a[r*ELEM_W +: ELEM_W])
        );
    end

    // Column c of B is strided in i_b, so gather it before loading its lane.
    for (genvar c = 0; c < N; c++) begin : g_col
        logic [N*ELEM_W-1:0] col;
        for (genvar k = 0; k < N; k++) begin : g_k
            assign col[k*ELEM_W +: ELEM_W] = i_b[(k*N+c)*ELEM_W +: ELEM_W];
        end
        sa_skew_feeder_lane #(.N(N), .W(ELEM_W), .D(c)) u_lane (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .i_load   (accept),
            .i_vec    (col),
            .o_lane   (o_b[c*ELEM_W +: ELEM_W])
        );
    end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: directed + random checks of lane skew, handshake timing and reset abort.
module tb_sa_skew_feeder;
    localparam int N = 4;
    localparam int W = 8;
    localparam int FL = 3 * N - 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_valid = 1'b0;
    logic [N*N*W-1:0] a_in = '0;
    logic [N*N*W-1:0] b_in = '0;
    logic start_ready, busy, done;
    logic [N*W-1:0] a_out, b_out;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];
    logic [15:0] mac [N][N];
    logic [W-1:0] pa [N][N];
    logic [W-1:0] pb [N][N];

    always #5 clk = ~clk;

    sa_skew_feeder #(.N(N), .ELEM_W(W)) dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_a           (a_in),
        .i_b           (b_in),
        .o_a           (a_out),
        .o_b           (b_out),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] lanes_a(input int t);
        logic [N*W-1:0] v = '0;
        for (int r = 0; r < N; r++)
            if (t - r >= 0 && t - r < N) v[r*W +: W] = ma[r][t-r];
        return v;
    endfunction

    function automatic logic [N*W-1:0] lanes_b(input int t);
        logic [N*W-1:0] v = '0;
        for (int c = 0; c < N; c++)
            if (t - c >= 0 && t - c < N) v[c*W +: W] = mb[t-c][c];
        return v;
    endfunction

    task automatic load_mats();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                a_in[(r*N+k)*W +: W] = ma[r][k];
                b_in[(r*N+k)*W +: W] = mb[r][k];
            end
    endtask

    task automatic rand_mats();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                ma[r][k] = 8'($urandom);
                mb[r][k] = 8'($urandom);
            end
    endtask

    task automatic mesh_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mac[r][c] = '0;
                pa[r][c] = '0;
                pb[r][c] = '0;
            end
    endtask

    // One clock of an NxN mesh of registered MAC cells fed by the observed edge lanes.
    task automatic mesh_step();
        logic [W-1:0] na [N][N];
        logic [W-1:0] nb [N][N];
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                na[r][c] = (c == 0) ? a_out[r*W +: W] : pa[r][c-1];
                nb[r][c] = (r == 0) ? b_out[c*W +: W] : pb[r-1][c];
                mac[r][c] = mac[r][c] + 16'(na[r][c]) * 16'(nb[r][c]);
            end
        pa = na;
        pb = nb;
    endtask

    task automatic do_op(input bit scramble);
        logic [15:0] e;
        load_mats();
        mesh_clear();
        check("ready_before_start", 64'(start_ready), 64'(1));
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        if (scramble) begin
            a_in = '1;
            b_in = '1;
        end
        check("ready_in_feed", 64'(start_ready), 64'(0));
        for (int t = 0; t < FL; t++) begin
            check($sformatf("lane_a t=%0d", t), 64'(a_out), 64'(lanes_a(t)));
            check($sformatf("lane_b t=%0d", t), 64'(b_out), 64'(lanes_b(t)));
            check($sformatf("busy t=%0d", t), 64'(busy), 64'(1));
            check($sformatf("done_early t=%0d", t), 64'(done), 64'(0));
            mesh_step();
            @(negedge clk);
        end
        check("done_pulse", 64'(done), 64'(1));
        check("busy_done", 64'(busy), 64'(1));
        check("ready_done", 64'(start_ready), 64'(0));
        check("lane_a_done", 64'(a_out), 64'(0));
        check("lane_b_done", 64'(b_out), 64'(0));
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                e = '0;
                for (int k = 0; k < N; k++) e = e + 16'(ma[r][k]) * 16'(mb[k][c]);
                check($sformatf("product[%0d][%0d]", r, c), 64'(mac[r][c]), 64'(e));
            end
        @(negedge clk);
        check("done_single", 64'(done), 64'(0));
        check("ready_after", 64'(start_ready), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
    endtask

    initial begin
        int last;
        int accepts;
        int dones;
        @(negedge clk);
        check("rst_ready", 64'(start_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_lane_a", 64'(a_out), 64'(0));
        check("rst_lane_b", 64'(b_out), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            check("idle_lane_a", 64'(a_out), 64'(0));
            check("idle_lane_b", 64'(b_out), 64'(0));
            check("idle_done", 64'(done), 64'(0));
            @(negedge clk);
        end

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 8'd1 : 8'd0;
                mb[r][c] = 8'(4 * r + c + 1);
            end
        do_op(1'b0);

        rand_mats();
        do_op(1'b1);
        for (int i = 0; i < 4; i++) begin
            rand_mats();
            do_op(1'b0);
        end

        // Held-high start: accepts only from IDLE, spaced 3N apart.
        rand_mats();
        load_mats();
        start_valid = 1'b1;
        last = -1;
        accepts = 0;
        dones = 0;
        for (int cyc = 0; cyc < 9 * N; cyc++) begin
            if (done) dones++;
            if (start_ready) begin
                if (last >= 0) check("start_spacing", 64'(cyc - last), 64'(3 * N));
                last = cyc;
                accepts++;
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        check("held_accepts", 64'(accepts), 64'(3));
        check("held_dones", 64'(dones), 64'(3));
        check("held_ready_end", 64'(start_ready), 64'(1));
        @(negedge clk);

        // Abort at t=2 with an asynchronous reset.
        rand_mats();
        load_mats();
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        check("abort_lane_a t=0", 64'(a_out), 64'(lanes_a(0)));
        @(negedge clk);
        @(negedge clk);
        check("abort_lane_a t=2", 64'(a_out), 64'(lanes_a(2)));
        check("abort_lane_b t=2", 64'(b_out), 64'(lanes_b(2)));
        #1 rst_n = 1'b0;
        #1;
        check("abort_lane_a", 64'(a_out), 64'(0));
        check("abort_lane_b", 64'(b_out), 64'(0));
        check("abort_ready", 64'(start_ready), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * N; i++) begin
            check("post_abort_done", 64'(done), 64'(0));
            check("post_abort_lane_a", 64'(a_out), 64'(0));
            @(negedge clk);
        end
        rand_mats();
        do_op(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
